// File: rtl/fifo_pong_arbiter_if.sv
// Requester-side and FIFO-side handshake bundle for fifo_pong_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface fifo_pong_arbiter_if #(
    parameter int width = 704,
    parameter int NREQ  = 4
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]       req_want;
    logic [NREQ-1:0]       req_enq__ENA;
    logic [NREQ*width-1:0] req_enq_v;
    logic [NREQ-1:0]       req_enq_last;
    logic [NREQ-1:0]       req_enq__RDY;
    logic                  fifo_enq__ENA;
    logic [width-1:0]      fifo_enq_v;
    logic                  fifo_enq__RDY;
    logic [OW-1:0]         owner;
    logic                  locked;
    logic [31:0]           msg_count;
    logic                  proto_err;

    modport slave (
        input  req_want, req_enq__ENA, req_enq_v, req_enq_last, fifo_enq__RDY,
        output req_enq__RDY, fifo_enq__ENA, fifo_enq_v, owner, locked, msg_count, proto_err
    );

    modport master (
        output req_want, req_enq__ENA, req_enq_v, req_enq_last, fifo_enq__RDY,
        input  req_enq__RDY, fifo_enq__ENA, fifo_enq_v, owner, locked, msg_count, proto_err
    );
endinterface

// File: rtl/fifo_pong_arbiter.sv
// Round-robin, message-locked arbiter sharing one FIFO enqueue port among NREQ requesters.
// Guards and forwarding are combinational; ownership, pointer and counters update on CLK.
module fifo_pong_arbiter #(
    parameter int width = 704,
    parameter int NREQ  = 4
) (
    input logic               CLK,
    input logic               RST,
    fifo_pong_arbiter_if.slave bus
);
    localparam int OW = $clog2(NREQ);
    typedef logic [OW-1:0] idx_t;
    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t          state_q, state_d;
    idx_t            owner_q, owner_d;
    idx_t            ptr_q, ptr_d;
    idx_t            pick, cand, grant;
    logic [31:0]     cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            want_any, found;
    logic [NREQ-1:0] rdy, acc;

    assign want_any = |bus.req_want;

    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = idx_t'((32'(ptr_q) + k) % 32'(NREQ));
            if (!found && bus.req_want[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        rdy = '0;
        if (!RST && bus.fifo_enq__RDY) begin
            if (state_q == S_LOCKED)
                rdy[owner_q] = 1'b1;
            else if (want_any)
                rdy[pick] = 1'b1;
        end
    end

    // At most one RDY bit is set, so acc is one-hot or zero and grant is its index.
    assign acc = bus.req_enq__ENA & rdy;

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            if (acc[i]) grant = idx_t'(i);
    end

    assign bus.req_enq__RDY  = rdy;
    assign bus.fifo_enq__ENA = |acc;
    assign bus.fifo_enq_v    = bus.fifo_enq__ENA ? bus.req_enq_v[grant*width +: width] : '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q | (|(bus.req_enq__ENA & ~rdy));
        if (bus.fifo_enq__ENA) begin
            owner_d = grant;
            if (bus.req_enq_last[grant]) begin
                state_d = S_IDLE;
                ptr_d   = (grant == idx_t'(NREQ - 1)) ? '0 : grant + idx_t'(1);
                cnt_d   = cnt_q + 32'd1;
            end else begin
                state_d = S_LOCKED;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.owner     = owner_q;
    assign bus.locked    = (state_q == S_LOCKED);
    assign bus.msg_count = cnt_q;
    assign bus.proto_err = err_q;
endmodule

// File: tb/tb_fifo_pong_arbiter.sv
// Bench for fifo_pong_arbiter: fixed vector table, directed reset/wrap sequences,
// and randomized traffic against a queue-free behavioural model of the arbitration rules.
module tb_fifo_pong_arbiter;
    localparam int W = 704;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_pong_arbiter_if #(.width(W), .NREQ(N)) bus ();
    fifo_pong_arbiter #(.width(W), .NREQ(N)) dut (.CLK(clk), .RST(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    logic [31:0] m_cnt;
    bit          m_err;

    typedef struct {
        logic [N-1:0] want, ena, last;
        logic         frdy;
        logic [N-1:0] rdy;
        logic         fena;
        logic         lck;
        int           own;
        logic [31:0]  cnt;
        logic         err;
    } vec_t;
    vec_t tv[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pat(input int i);
        logic [W-1:0] v;
        for (int w = 0; w < W / 32; w++) v[w*32 +: 32] = {8'(8'h10 + i), 24'(w * 7 + 1)};
        return v;
    endfunction

    function automatic logic [N-1:0] m_rdy(input logic r, input logic [N-1:0] want, input logic frdy);
        logic [N-1:0] res = '0;
        if (r || !frdy) return res;
        if (m_locked) begin
            res[m_owner] = 1'b1;
            return res;
        end
        for (int k = 0; k < N; k++)
            if (want[(m_ptr + k) % N]) begin
                res[(m_ptr + k) % N] = 1'b1;
                return res;
            end
        return res;
    endfunction

    task automatic m_step(input logic r, input logic [N-1:0] want, ena, last, input logic frdy);
        logic [N-1:0] er, acc;
        if (r) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = '0; m_err = 0;
            return;
        end
        er  = m_rdy(1'b0, want, frdy);
        acc = ena & er;
        if ((ena & ~er) != '0) m_err = 1;
        for (int i = 0; i < N; i++)
            if (acc[i]) begin
                m_owner = i;
                if (last[i]) begin
                    m_locked = 0;
                    m_ptr    = (i + 1) % N;
                    m_cnt    = m_cnt + 32'd1;
                end else begin
                    m_locked = 1;
                end
            end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] want, ena, last,
                         input logic frdy, input logic [N*W-1:0] data);
        rst               = r;
        bus.req_want      = want;
        bus.req_enq__ENA  = ena;
        bus.req_enq_last  = last;
        bus.fifo_enq__RDY = frdy;
        bus.req_enq_v     = data;
    endtask

    // Entered at posedge+1; combinational checks at the falling edge, state checks at posedge+1.
    task automatic mcycle(input string tag, input logic r, input logic [N-1:0] want, ena, last,
                          input logic frdy, input logic [N*W-1:0] data);
        logic [N-1:0] er, acc;
        logic [W-1:0] ev;
        drive(r, want, ena, last, frdy, data);
        er  = m_rdy(r, want, frdy);
        acc = ena & er;
        ev  = '0;
        for (int i = 0; i < N; i++) if (acc[i]) ev = data[i*W +: W];
        #4;
        check({tag, ".rdy"},  W'(bus.req_enq__RDY), W'(er));
        check({tag, ".fena"}, W'(bus.fifo_enq__ENA), W'(acc != '0));
        check({tag, ".fv"},   bus.fifo_enq_v, ev);
        @(posedge clk);
        m_step(r, want, ena, last, frdy);
        #1;
        check({tag, ".locked"}, W'(bus.locked), W'(m_locked));
        check({tag, ".owner"},  W'(bus.owner), W'(m_owner));
        check({tag, ".count"},  W'(bus.msg_count), W'(m_cnt));
        check({tag, ".err"},    W'(bus.proto_err), W'(m_err));
    endtask

    function automatic vec_t mk(input logic [N-1:0] want, ena, last, input logic frdy,
                                input logic [N-1:0] rdy, input logic fena, input logic lck,
                                input int own, input logic [31:0] cnt, input logic err);
        vec_t v;
        v.want = want; v.ena = ena; v.last = last; v.frdy = frdy; v.rdy = rdy;
        v.fena = fena; v.lck = lck; v.own = own; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N*W-1:0] pdata;
        logic [N*W-1:0] rdata;
        logic [W-1:0]   ev;
        logic [N-1:0]   er, rw, re, rl;
        logic           rr, rf;

        for (int i = 0; i < N; i++) pdata[i*W +: W] = pat(i);

        // round robin over 0 and 2
        tv.push_back(mk(4'b0101, 4'b0001, 4'b1111, 1, 4'b0001, 1, 0, 0, 1, 0));
        tv.push_back(mk(4'b0101, 4'b0100, 4'b1111, 1, 4'b0100, 1, 0, 2, 2, 0));
        tv.push_back(mk(4'b0101, 4'b0001, 4'b1111, 1, 4'b0001, 1, 0, 0, 3, 0));
        tv.push_back(mk(4'b0101, 4'b0100, 4'b1111, 1, 4'b0100, 1, 0, 2, 4, 0));
        tv.push_back(mk(4'b0001, 4'b0001, 4'b1111, 1, 4'b0001, 1, 0, 0, 5, 0));
        // requester 1 three-beat message with requester 3 waiting, then 3 wins over 0
        tv.push_back(mk(4'b1010, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 1, 5, 0));
        tv.push_back(mk(4'b1010, 4'b0000, 4'b0000, 1, 4'b0010, 0, 1, 1, 5, 0));
        tv.push_back(mk(4'b1010, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 1, 5, 0));
        tv.push_back(mk(4'b1010, 4'b0010, 4'b0010, 1, 4'b0010, 1, 0, 1, 6, 0));
        tv.push_back(mk(4'b1001, 4'b1000, 4'b1000, 1, 4'b1000, 1, 0, 3, 7, 0));
        // lock held across five FIFO-full cycles
        tv.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 1, 0, 7, 0));
        for (int s = 0; s < 5; s++)
            tv.push_back(mk(4'b0101, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0, 7, 0));
        tv.push_back(mk(4'b0101, 4'b0001, 4'b0001, 1, 4'b0001, 1, 0, 0, 8, 0));
        // requester 2 pushes illegally while 0 owns the lock
        tv.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 1, 0, 8, 0));
        tv.push_back(mk(4'b0101, 4'b0101, 4'b0000, 1, 4'b0001, 1, 1, 0, 8, 1));
        tv.push_back(mk(4'b0101, 4'b0100, 4'b0100, 1, 4'b0001, 0, 1, 0, 8, 1));
        tv.push_back(mk(4'b0001, 4'b0001, 4'b0001, 1, 4'b0001, 1, 0, 0, 9, 1));

        drive(1'b1, '0, '0, '0, 1'b1, pdata);
        @(posedge clk);
        #1;
        mcycle("reset0", 1, 4'b1111, 4'b0000, 4'b0000, 1, pdata);
        mcycle("reset1", 1, 4'b1111, 4'b0000, 4'b0000, 1, pdata);

        for (int n = 0; n < tv.size(); n++) begin
            drive(0, tv[n].want, tv[n].ena, tv[n].last, tv[n].frdy, pdata);
            ev = '0;
            for (int i = 0; i < N; i++) if (tv[n].fena && tv[n].rdy[i]) ev = pat(i);
            #4;
            check($sformatf("vec%0d.rdy", n),  W'(bus.req_enq__RDY), W'(tv[n].rdy));
            check($sformatf("vec%0d.fena", n), W'(bus.fifo_enq__ENA), W'(tv[n].fena));
            check($sformatf("vec%0d.fv", n),   bus.fifo_enq_v, ev);
            @(posedge clk);
            m_step(0, tv[n].want, tv[n].ena, tv[n].last, tv[n].frdy);
            #1;
            check($sformatf("vec%0d.locked", n), W'(bus.locked), W'(tv[n].lck));
            check($sformatf("vec%0d.owner", n),  W'(bus.owner), W'(tv[n].own));
            check($sformatf("vec%0d.count", n),  W'(bus.msg_count), W'(tv[n].cnt));
            check($sformatf("vec%0d.err", n),    W'(bus.proto_err), W'(tv[n].err));
        end

        // reset in the middle of a four-beat message from requester 3
        mcycle("mr.rst", 1, 4'b0000, 4'b0000, 4'b0000, 1, pdata);
        mcycle("mr.b1", 0, 4'b1000, 4'b1000, 4'b0000, 1, pdata);
        mcycle("mr.b2", 0, 4'b1000, 4'b1000, 4'b0000, 1, pdata);
        drive(1, 4'b1111, 4'b0000, 4'b0000, 1, pdata);
        #4;
        check("mr.rdy_in_reset", W'(bus.req_enq__RDY), W'(4'b0000));
        check("mr.fena_in_reset", W'(bus.fifo_enq__ENA), W'(1'b0));
        @(posedge clk);
        m_step(1, 4'b1111, 4'b0000, 4'b0000, 1);
        #1;
        check("mr.locked", W'(bus.locked), W'(1'b0));
        check("mr.count", W'(bus.msg_count), W'(32'd0));
        drive(0, 4'b1111, 4'b0000, 4'b0000, 1, pdata);
        #1;
        check("mr.first_grant", W'(bus.req_enq__RDY), W'(4'b0001));
        mcycle("mr.g0", 0, 4'b1111, 4'b0001, 4'b0001, 1, pdata);

        // msg_count wrap
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        #1;
        check("wrap.preload", W'(bus.msg_count), W'(32'hFFFF_FFFE));
        for (int k = 0; k < 3; k++)
            mcycle($sformatf("wrap%0d", k), 0, 4'b0001, 4'b0001, 4'b0001, 1, pdata);
        check("wrap.final", W'(bus.msg_count), W'(32'd1));

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rr = ($urandom_range(0, 99) == 0);
            rw = N'($urandom);
            rf = ($urandom_range(0, 3) != 0);
            rl = '0;
            for (int i = 0; i < N; i++) rl[i] = ($urandom_range(0, 9) < 4);
            er = m_rdy(rr, rw, rf);
            re = er & N'($urandom);
            if ($urandom_range(0, 29) == 0) re = re | N'($urandom);
            for (int w = 0; w < N * W / 32; w++) rdata[w*32 +: 32] = $urandom;
            mcycle($sformatf("rnd%0d", c), rr, rw, re, rl, rf, rdata);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
